// File: rtl/cdb_issue_unit.sv
// Tomasulo issue arbiter and CDB producer: round-robin issue of ready station heads,
// CDB slot reservation by FU latency, result capture and broadcast.
module cdb_issue_unit #(
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INT_LAT   = 1,
  parameter int unsigned LD_ST_LAT = 2,
  parameter int unsigned MULT_LAT  = 4,
  parameter int unsigned DIV_LAT   = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              int_ready,
  input  logic              ld_st_ready,
  input  logic              mult_ready,
  input  logic              div_ready,
  output logic              int_rd,
  output logic              ld_st_rd,
  output logic              mult_rd,
  output logic              div_rd,
  input  logic              int_res_valid,
  input  logic [TAG_W-1:0]  int_res_tag,
  input  logic [DATA_W-1:0] int_res_data,
  input  logic              int_res_branch,
  input  logic              int_res_branch_taken,
  input  logic              ld_st_res_valid,
  input  logic [TAG_W-1:0]  ld_st_res_tag,
  input  logic [DATA_W-1:0] ld_st_res_data,
  input  logic              mult_res_valid,
  input  logic [TAG_W-1:0]  mult_res_tag,
  input  logic [DATA_W-1:0] mult_res_data,
  input  logic              div_res_valid,
  input  logic [TAG_W-1:0]  div_res_tag,
  input  logic [DATA_W-1:0] div_res_data,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_branch,
  output logic              cdb_branch_taken,
  output logic              cdb_err
);

  localparam int unsigned MAX_A = (INT_LAT > LD_ST_LAT) ? INT_LAT : LD_ST_LAT;
  localparam int unsigned MAX_B = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam logic [1:0] U_INT  = 2'd0;
  localparam logic [1:0] U_LDST = 2'd1;
  localparam logic [1:0] U_MULT = 2'd2;
  localparam logic [1:0] U_DIV  = 2'd3;

  logic [MAXL:0]      slot_q, slot_d;
  logic [MAXL:0][1:0] unit_q, unit_d;
  logic               div_busy_q, div_busy_d;
  logic [1:0]         rr_q, rr_d;
  logic               err_d;
  logic [3:0]         elig, grant;
  logic               found;
  logic [1:0]         win, idx;
  logic               cap;
  logic [1:0]         sel;
  logic               sel_valid;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_data;
  logic               spurious;

  // A unit may issue only if its return slot on the CDB is still free
  assign elig[0] = int_ready   & ~slot_q[INT_LAT];
  assign elig[1] = ld_st_ready & ~slot_q[LD_ST_LAT];
  assign elig[2] = mult_ready  & ~slot_q[MULT_LAT];
  assign elig[3] = div_ready   & ~slot_q[DIV_LAT] & ~div_busy_q;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        win        = idx;
      end
    end
  end

  assign int_rd   = grant[0] & ~i_rst;
  assign ld_st_rd = grant[1] & ~i_rst;
  assign mult_rd  = grant[2] & ~i_rst;
  assign div_rd   = grant[3] & ~i_rst;

  // Result mux driven by the unit that owns the current slot
  always_comb begin
    cap       = slot_q[0];
    sel       = unit_q[0];
    sel_valid = 1'b0;
    sel_tag   = '0;
    sel_data  = '0;
    case (sel)
      U_INT:   begin sel_valid = int_res_valid;   sel_tag = int_res_tag;   sel_data = int_res_data;   end
      U_LDST:  begin sel_valid = ld_st_res_valid; sel_tag = ld_st_res_tag; sel_data = ld_st_res_data; end
      U_MULT:  begin sel_valid = mult_res_valid;  sel_tag = mult_res_tag;  sel_data = mult_res_data;  end
      default: begin sel_valid = div_res_valid;   sel_tag = div_res_tag;   sel_data = div_res_data;   end
    endcase
  end

  assign spurious = (int_res_valid   & ~(cap & (sel == U_INT)))
                  | (ld_st_res_valid & ~(cap & (sel == U_LDST)))
                  | (mult_res_valid  & ~(cap & (sel == U_MULT)))
                  | (div_res_valid   & ~(cap & (sel == U_DIV)));

  always_comb begin
    slot_d     = {1'b0, slot_q[MAXL:1]};
    unit_d     = {2'b00, unit_q[MAXL:1]};
    div_busy_d = div_busy_q;
    rr_d       = rr_q;
    err_d      = cdb_err | (cap & ~sel_valid) | spurious;
    if (cap && sel == U_DIV) div_busy_d = 1'b0;
    if (found) rr_d = win + 2'd1;
    if (grant[0]) begin slot_d[INT_LAT-1]   = 1'b1; unit_d[INT_LAT-1]   = U_INT;  end
    if (grant[1]) begin slot_d[LD_ST_LAT-1] = 1'b1; unit_d[LD_ST_LAT-1] = U_LDST; end
    if (grant[2]) begin slot_d[MULT_LAT-1]  = 1'b1; unit_d[MULT_LAT-1]  = U_MULT; end
    if (grant[3]) begin
      slot_d[DIV_LAT-1] = 1'b1;
      unit_d[DIV_LAT-1] = U_DIV;
      div_busy_d        = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q           <= '0;
      unit_q           <= '0;
      div_busy_q       <= 1'b0;
      rr_q             <= '0;
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      cdb_err          <= 1'b0;
    end else begin
      slot_q           <= slot_d;
      unit_q           <= unit_d;
      div_busy_q       <= div_busy_d;
      rr_q             <= rr_d;
      cdb_valid        <= cap;
      cdb_tag          <= cap ? sel_tag : '0;
      cdb_data         <= cap ? sel_data : '0;
      cdb_branch       <= cap & (sel == U_INT) & int_res_branch;
      cdb_branch_taken <= cap & (sel == U_INT) & int_res_branch_taken;
      cdb_err          <= err_d;
    end
  end

endmodule

// File: tb/tb_cdb_issue_unit.sv
// Randomized and directed bench for cdb_issue_unit against a cycle-indexed booking model.
module tb_cdb_issue_unit;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int N = 1024;
  localparam int LAT [4] = '{1, 2, 4, 6};

  logic i_clk = 1'b0;
  logic i_rst;
  logic int_ready, ld_st_ready, mult_ready, div_ready;
  logic int_rd, ld_st_rd, mult_rd, div_rd;
  logic int_res_valid, int_res_branch, int_res_branch_taken;
  logic ld_st_res_valid, mult_res_valid, div_res_valid;
  logic [TAG_W-1:0]  int_res_tag, ld_st_res_tag, mult_res_tag, div_res_tag, cdb_tag;
  logic [DATA_W-1:0] int_res_data, ld_st_res_data, mult_res_data, div_res_data, cdb_data;
  logic cdb_valid, cdb_branch, cdb_branch_taken, cdb_err;

  always #5 i_clk = ~i_clk;

  cdb_issue_unit dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .int_ready(int_ready), .ld_st_ready(ld_st_ready), .mult_ready(mult_ready), .div_ready(div_ready),
    .int_rd(int_rd), .ld_st_rd(ld_st_rd), .mult_rd(mult_rd), .div_rd(div_rd),
    .int_res_valid(int_res_valid), .int_res_tag(int_res_tag), .int_res_data(int_res_data),
    .int_res_branch(int_res_branch), .int_res_branch_taken(int_res_branch_taken),
    .ld_st_res_valid(ld_st_res_valid), .ld_st_res_tag(ld_st_res_tag), .ld_st_res_data(ld_st_res_data),
    .mult_res_valid(mult_res_valid), .mult_res_tag(mult_res_tag), .mult_res_data(mult_res_data),
    .div_res_valid(div_res_valid), .div_res_tag(div_res_tag), .div_res_data(div_res_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken), .cdb_err(cdb_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: which unit owns each absolute cycle's CDB return, and what the CDB shows per cycle
  int t, rr, div_free_at;
  bit err;
  int booked [N];
  logic [TAG_W-1:0]  r_tag [N];
  logic [DATA_W-1:0] r_data [N];
  bit r_br [N], r_tk [N], r_wh [N];
  bit e_valid [N], e_br [N], e_tk [N];
  logic [TAG_W-1:0]  e_tag [N];
  logic [DATA_W-1:0] e_data [N];

  bit ovr_en, ovr_br, ovr_tk;
  logic [TAG_W-1:0]  ovr_tag;
  logic [DATA_W-1:0] ovr_data;
  bit withhold_ldst, spurious_div;
  logic [3:0] obs_rd;

  task automatic clear_model();
    t = 0; rr = 0; div_free_at = 0; err = 0;
    for (int i = 0; i < N; i++) begin
      booked[i] = -1; r_wh[i] = 0; e_valid[i] = 0; e_br[i] = 0; e_tk[i] = 0;
      e_tag[i] = '0; e_data[i] = '0;
    end
  endtask

  task automatic idle_inputs();
    {div_ready, mult_ready, ld_st_ready, int_ready} = 4'b0000;
    int_res_valid = 0; ld_st_res_valid = 0; mult_res_valid = 0; div_res_valid = 0;
    int_res_tag = '0; ld_st_res_tag = '0; mult_res_tag = '0; div_res_tag = '0;
    int_res_data = '0; ld_st_res_data = '0; mult_res_data = '0; div_res_data = '0;
    int_res_branch = 0; int_res_branch_taken = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, 64'({div_rd, mult_rd, ld_st_rd, int_rd}), 64'd0);
    check({tag, "_valid"}, 64'(cdb_valid), 64'd0);
    check({tag, "_tag"}, 64'(cdb_tag), 64'd0);
    check({tag, "_data"}, 64'(cdb_data), 64'd0);
    check({tag, "_br"}, 64'({cdb_branch, cdb_branch_taken}), 64'd0);
    check({tag, "_err"}, 64'(cdb_err), 64'd0);
  endtask

  // Called at a negedge; drives cycle t, checks it, advances the model, returns at next negedge
  task automatic cycle(input logic [3:0] rdy);
    int win, u, d;
    logic [3:0] exp_rd;
    {div_ready, mult_ready, ld_st_ready, int_ready} = rdy;
    int_res_valid = 0; ld_st_res_valid = 0; mult_res_valid = 0; div_res_valid = 0;
    int_res_tag = TAG_W'($urandom); ld_st_res_tag = TAG_W'($urandom);
    mult_res_tag = TAG_W'($urandom); div_res_tag = TAG_W'($urandom);
    int_res_data = $urandom; ld_st_res_data = $urandom; mult_res_data = $urandom; div_res_data = $urandom;
    int_res_branch = 1'($urandom); int_res_branch_taken = 1'($urandom);
    case (booked[t])
      0: begin int_res_valid = !r_wh[t]; int_res_tag = r_tag[t]; int_res_data = r_data[t];
               int_res_branch = r_br[t]; int_res_branch_taken = r_tk[t]; end
      1: begin ld_st_res_valid = !r_wh[t]; ld_st_res_tag = r_tag[t]; ld_st_res_data = r_data[t]; end
      2: begin mult_res_valid = !r_wh[t]; mult_res_tag = r_tag[t]; mult_res_data = r_data[t]; end
      3: begin div_res_valid = !r_wh[t]; div_res_tag = r_tag[t]; div_res_data = r_data[t]; end
      default: ;
    endcase
    if (spurious_div) div_res_valid = 1;
    #1;
    win = -1;
    for (int i = 0; i < 4; i++) begin
      u = (rr + i) % 4;
      if (win < 0 && rdy[u] && booked[t + LAT[u]] < 0 && (u != 3 || t >= div_free_at)) win = u;
    end
    exp_rd = (win < 0) ? 4'b0000 : 4'(1 << win);
    obs_rd = {div_rd, mult_rd, ld_st_rd, int_rd};
    check("rd", 64'(obs_rd), 64'(exp_rd));
    check("cdb_valid", 64'(cdb_valid), 64'(e_valid[t]));
    check("cdb_tag", 64'(cdb_tag), 64'(e_tag[t]));
    check("cdb_data", 64'(cdb_data), 64'(e_data[t]));
    check("cdb_branch", 64'({cdb_branch, cdb_branch_taken}), 64'({e_br[t], e_tk[t]}));
    check("cdb_err", 64'(cdb_err), 64'(err));
    if (booked[t] >= 0 && r_wh[t]) err = 1;
    if (spurious_div) err = 1;
    if (win >= 0) begin
      rr = (win + 1) % 4;
      d = t + LAT[win];
      booked[d] = win;
      r_tag[d]  = ovr_en ? ovr_tag  : TAG_W'($urandom);
      r_data[d] = ovr_en ? ovr_data : $urandom;
      r_br[d]   = ovr_en ? ovr_br   : 1'($urandom);
      r_tk[d]   = ovr_en ? ovr_tk   : 1'($urandom);
      r_wh[d]   = (win == 1) && withhold_ldst;
      if (win == 1) withhold_ldst = 0;
      ovr_en = 0;
      e_valid[d+1] = 1; e_tag[d+1] = r_tag[d]; e_data[d+1] = r_data[d];
      e_br[d+1] = (win == 0) && r_br[d];
      e_tk[d+1] = (win == 0) && r_tk[d];
      if (win == 3) div_free_at = d + 1;
    end
    t++;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000);
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1;
    idle_inputs();
    {div_ready, mult_ready, ld_st_ready, int_ready} = 4'b1111;
    #1;
    check_zero(tag);
    @(negedge i_clk);
    i_rst = 0;
    clear_model();
  endtask

  int div_grants [$];

  initial begin
    ovr_en = 0; withhold_ldst = 0; spurious_div = 0;
    i_rst = 1;
    idle_inputs();
    repeat (2) @(negedge i_clk);
    do_reset("reset");

    // single int issue with a fixed result
    ovr_en = 1; ovr_tag = 6'h05; ovr_data = 32'h0000_00AA; ovr_br = 0; ovr_tk = 0;
    cycle(4'b0001);
    idle(4);

    // mult occupies int's return slot in cycle 3
    do_reset("rst_t2");
    cycle(4'b0100);
    idle(2);
    cycle(4'b0001);
    cycle(4'b0001);
    idle(4);

    // all units ready: round-robin and non-pipelined div
    do_reset("rst_t3");
    div_grants.delete();
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111);
      if (obs_rd[3]) div_grants.push_back(i);
    end
    idle(8);
    check("div_grant_count_ge2", 64'(div_grants.size() >= 2), 64'd1);
    if (div_grants.size() >= 2) check("second_div_not_early", 64'(div_grants[1] >= 9), 64'd1);

    // branch resolution on int, then plain mult
    do_reset("rst_t4");
    ovr_en = 1; ovr_tag = 6'h12; ovr_data = $urandom; ovr_br = 1; ovr_tk = 1;
    cycle(4'b0001);
    idle(3);
    cycle(4'b0100);
    idle(6);

    // withheld ld_st result
    do_reset("rst_t5a");
    withhold_ldst = 1;
    cycle(4'b0010);
    idle(6);

    // spurious div result
    do_reset("rst_t5b");
    idle(1);
    spurious_div = 1;
    cycle(4'b0000);
    spurious_div = 0;
    idle(4);

    // async reset with mult and div in flight
    do_reset("rst_t6");
    cycle(4'b0100);
    cycle(4'b1000);
    cycle(4'b0000);
    #2;
    i_rst = 1;
    {div_ready, mult_ready, ld_st_ready, int_ready} = 4'b1111;
    #1;
    check_zero("async_rst");
    idle_inputs();
    @(negedge i_clk);
    i_rst = 0;
    clear_model();
    idle(10);

    // random legal traffic
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) cycle(4'($urandom));
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
